// File: rtl/packet_ring_allocator.sv
// packet_ring_allocator
// Per-port ring-buffer address manager for the external QDR-II+ packet buffer.
// The RAM is split into NUM_PORTS equal regions addressed as {port, offset}.
// Each port keeps a tentative write pointer, a committed write pointer and a
// read pointer, each carrying a wrap bit above the region offset. Whole
// frames are committed or rolled back on the last word.
// Optional feature: define PACKET_BUFFER_STATS_EN for per-port saturating
// drop counters readable through stats_sel / stats_drops.
module packet_ring_allocator #(
    parameter int NUM_PORTS   = 15,
    parameter int PORT_BITS   = 4,
    parameter int REGION_BITS = 14,
    parameter int DATA_WIDTH  = 144
) (
    input  logic                             i_clk_ram_ctl,
    input  logic                             i_rst_n,
    input  logic [NUM_PORTS-1:0]             i_port_flush,
    input  logic                             i_wr_valid,
    input  logic [PORT_BITS-1:0]             i_wr_port,
    input  logic                             i_wr_last,
    input  logic                             i_wr_drop,
    input  logic [DATA_WIDTH-1:0]            i_wr_data,
    input  logic                             i_rd_req,
    input  logic [PORT_BITS-1:0]             i_rd_port,
    output logic                             o_ram_wr_en,
    output logic [PORT_BITS+REGION_BITS-1:0] o_ram_wr_addr,
    output logic [DATA_WIDTH-1:0]            o_ram_wr_data,
    output logic                             o_ram_rd_en,
    output logic [PORT_BITS+REGION_BITS-1:0] o_ram_rd_addr,
    output logic                             o_rd_ack,
    output logic [NUM_PORTS-1:0]             o_port_empty,
    output logic                             o_frame_committed,
    output logic                             o_frame_dropped,
    input  logic [PORT_BITS-1:0]             i_stats_sel,
    output logic [31:0]                      o_stats_drops
);

    localparam int AW = PORT_BITS + REGION_BITS;

    // Pointer distance meaning "region completely occupied".
    localparam logic [REGION_BITS:0] FULL_DIST = {1'b1, {REGION_BITS{1'b0}}};
    localparam logic [REGION_BITS:0] PTR_ONE   = {{REGION_BITS{1'b0}}, 1'b1};

    logic [REGION_BITS:0]  r_twr [NUM_PORTS];
    logic [REGION_BITS:0]  r_cwr [NUM_PORTS];
    logic [REGION_BITS:0]  r_rd  [NUM_PORTS];
    logic [NUM_PORTS-1:0]  r_ovf;

    logic [REGION_BITS:0]  w_twr_nx [NUM_PORTS];
    logic [REGION_BITS:0]  w_cwr_nx [NUM_PORTS];
    logic [REGION_BITS:0]  w_rd_nx  [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_ovf_nx;
    logic [NUM_PORTS-1:0]  w_empty_nx;
    logic [NUM_PORTS-1:0]  w_drop_vec;
    logic                  w_wr_fire;
    logic [AW-1:0]         w_wr_addr;
    logic                  w_rd_fire;
    logic [AW-1:0]         w_rd_addr;
    logic                  w_commit;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_ovf_eff;

    // Next-state pointer logic. Full uses the pre-read rd pointer and the read
    // side uses the pre-commit cwr pointer, so both checks are conservative
    // when a write and a read hit the same port in one cycle. Flush wins over
    // any write or read to the same port; port indices >= NUM_PORTS never
    // match the loop and are therefore ignored.
    always_comb begin
        w_wr_fire  = 1'b0;
        w_wr_addr  = '0;
        w_rd_fire  = 1'b0;
        w_rd_addr  = '0;
        w_commit   = 1'b0;
        w_drop     = 1'b0;
        w_drop_vec = '0;
        w_full     = 1'b0;
        w_ovf_eff  = 1'b0;
        w_ovf_nx   = r_ovf;
        w_empty_nx = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_twr_nx[p] = r_twr[p];
            w_cwr_nx[p] = r_cwr[p];
            w_rd_nx[p]  = r_rd[p];
            if (i_port_flush[p]) begin
                w_twr_nx[p] = '0;
                w_cwr_nx[p] = '0;
                w_rd_nx[p]  = '0;
                w_ovf_nx[p] = 1'b0;
            end else begin
                if (i_wr_valid && (i_wr_port == PORT_BITS'(p))) begin
                    w_full    = ((r_twr[p] - r_rd[p]) == FULL_DIST);
                    w_ovf_eff = r_ovf[p] | w_full;
                    if (!w_ovf_eff) begin
                        w_wr_fire   = 1'b1;
                        w_wr_addr   = {i_wr_port, r_twr[p][REGION_BITS-1:0]};
                        w_twr_nx[p] = r_twr[p] + PTR_ONE;
                    end
                    if (i_wr_last) begin
                        if (!w_ovf_eff && !i_wr_drop) begin
                            w_cwr_nx[p] = w_twr_nx[p];
                            w_commit    = 1'b1;
                        end else begin
                            w_twr_nx[p]   = r_cwr[p];
                            w_ovf_nx[p]   = 1'b0;
                            w_drop        = 1'b1;
                            w_drop_vec[p] = 1'b1;
                        end
                    end else begin
                        w_ovf_nx[p] = w_ovf_eff;
                    end
                end
                if (i_rd_req && (i_rd_port == PORT_BITS'(p)) && (r_cwr[p] != r_rd[p])) begin
                    w_rd_fire  = 1'b1;
                    w_rd_addr  = {i_rd_port, r_rd[p][REGION_BITS-1:0]};
                    w_rd_nx[p] = r_rd[p] + PTR_ONE;
                end
            end
            w_empty_nx[p] = (w_cwr_nx[p] == w_rd_nx[p]);
        end
    end

    // Pointer state and registered RAM/status outputs.
    always_ff @(posedge i_clk_ram_ctl or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_twr[p] <= '0;
                r_cwr[p] <= '0;
                r_rd[p]  <= '0;
            end
            r_ovf             <= '0;
            o_ram_wr_en       <= 1'b0;
            o_ram_wr_addr     <= '0;
            o_ram_wr_data     <= '0;
            o_ram_rd_en       <= 1'b0;
            o_ram_rd_addr     <= '0;
            o_rd_ack          <= 1'b0;
            o_port_empty      <= '1;
            o_frame_committed <= 1'b0;
            o_frame_dropped   <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_twr[p] <= w_twr_nx[p];
                r_cwr[p] <= w_cwr_nx[p];
                r_rd[p]  <= w_rd_nx[p];
            end
            r_ovf             <= w_ovf_nx;
            o_ram_wr_en       <= w_wr_fire;
            o_ram_wr_addr     <= w_wr_addr;
            if (w_wr_fire) begin
                o_ram_wr_data <= i_wr_data;
            end
            o_ram_rd_en       <= w_rd_fire;
            o_ram_rd_addr     <= w_rd_addr;
            o_rd_ack          <= w_rd_fire;
            o_port_empty      <= w_empty_nx;
            o_frame_committed <= w_commit;
            o_frame_dropped   <= w_drop;
        end
    end

`ifdef PACKET_BUFFER_STATS_EN
    logic [31:0] r_drop_cnt [NUM_PORTS];
    logic [31:0] w_stats_val;

    // Counter selected by stats_sel; out-of-range selects read as zero.
    always_comb begin
        w_stats_val = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (i_stats_sel == PORT_BITS'(p)) begin
                w_stats_val = r_drop_cnt[p];
            end
        end
    end

    // Saturating per-port drop counters, cleared together with the port.
    always_ff @(posedge i_clk_ram_ctl or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_drop_cnt[p] <= '0;
            end
            o_stats_drops <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (i_port_flush[p]) begin
                    r_drop_cnt[p] <= '0;
                end else if (w_drop_vec[p] && (r_drop_cnt[p] != 32'hFFFF_FFFF)) begin
                    r_drop_cnt[p] <= r_drop_cnt[p] + 32'd1;
                end
            end
            o_stats_drops <= w_stats_val;
        end
    end
`else
    logic w_unused_stats;
    assign w_unused_stats = ^{i_stats_sel, w_drop_vec};
    assign o_stats_drops  = '0;
`endif

endmodule

// File: doc/packet_ring_allocator.md
# packet_ring_allocator

Parametrised per-port ring-buffer address manager for the external QDR-II+ packet buffer, replacing fixed address handling between the ingress FIFO and the QDR2PController. Splits the RAM address space into NUM_PORTS equal regions. Tracks tentative-write, committed-write and read pointers per port, and commits or rolls back whole frames. Issues one registered RAM write and one registered RAM read per cycle on the controller clock.

## Interface
Parameters:
- NUM_PORTS, 15: ingress port count.
- PORT_BITS, 4: port index width; 2^PORT_BITS >= NUM_PORTS.
- REGION_BITS, 14: log2 of words per port region.
- DATA_WIDTH, 144: RAM word width.

Address width is PORT_BITS+REGION_BITS (18 at defaults). RAM address = {port, offset}.

Ports:
- clk_ram_ctl  in  1  controller clock; all logic is synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- port_flush  in  NUM_PORTS  per-port synchronous flush, e.g. on link down.
- wr_valid  in  1  write word presented.
- wr_port  in  PORT_BITS  port of the write word.
- wr_last  in  1  last word of frame.
- wr_drop  in  1  qualifies wr_last; discard the frame (bad FCS or VLAN reject).
- wr_data  in  DATA_WIDTH  write word.
- rd_req  in  1  request one word.
- rd_port  in  PORT_BITS  port to read.
- ram_wr_en  out  1  RAM write strobe.
- ram_wr_addr  out  PORT_BITS+REGION_BITS  RAM write address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_rd_en  out  1  RAM read strobe.
- ram_rd_addr  out  PORT_BITS+REGION_BITS  RAM read address.
- rd_ack  out  1  rd_req was granted; pulses together with ram_rd_en.
- port_empty  out  NUM_PORTS  no committed unread words for the port.
- frame_committed  out  1  pulse: frame accepted.
- frame_dropped  out  1  pulse: frame discarded.
- stats_sel  in  PORT_BITS  counter select (only with stats).
- stats_drops  out  32  drop count for stats_sel (only with stats).

## Operation
- Per port p, three pointers, each REGION_BITS+1 wide with a wrap bit: twr[p] (tentative write), cwr[p] (committed write), rd[p]. Reset value of all pointers is 0.
- Full: twr[p] - rd[p] == 2^REGION_BITS, computed modulo 2^(REGION_BITS+1).
- Empty: cwr[p] == rd[p]. port_empty[p] shows this state as registered.
- Each port has an ovf[p] flag.
- Write word with ovf clear and not full:
  - Issue a RAM write to {p, twr[p][REGION_BITS-1:0]}.
  - Increment twr[p].
- Write word while full:
  - Set ovf[p].
  - No RAM write.
  - Ignore all further words for p until wr_last.
- On wr_last, the last word itself is written if space allows. Then:
  - If ovf[p] is clear and wr_drop is low: cwr[p] <= the new twr[p], and frame_committed pulses.
  - Otherwise: twr[p] <= cwr[p], ovf[p] is cleared, and frame_dropped pulses.
- Read:
  - rd_req with rd_port not empty: ram_rd_en and rd_ack pulse, address {p, rd[p][REGION_BITS-1:0]}, rd[p] increments.
  - rd_req on an empty port: no read and no ack. This is not an error.
- Write and read on the same port in the same cycle:
  - Full is evaluated on the pre-read rd[p], so it is conservative by one word.
  - Empty is evaluated on the pre-commit cwr[p], so a frame committed in cycle N is readable from cycle N+1.
- port_flush[p]: all three pointers are set to 0 and ovf[p] is cleared. Flush has priority over a write or read to p in the same cycle; that write or read is suppressed. A frame in progress on p is lost, with no drop pulse.
- Words interleave freely across ports. Each port has its own independent frame state.
- wr_port or rd_port >= NUM_PORTS: the request is ignored.

## Timing
- All outputs are registered. Reset value of every output is 0, except port_empty, which resets to all 1s.
- Write latency: wr_valid in cycle N gives ram_wr_en/addr/data in cycle N+1.
- Read latency: rd_req in cycle N gives ram_rd_en and rd_ack in cycle N+1. Read data returns via the controller's rd_valid and is not handled here.
- frame_committed, frame_dropped and port_empty update in cycle N+1 after wr_last.
- Asynchronous reset mid-frame discards all state, with no pulses.
- Throughput: one write and one read per cycle sustained, with no back-pressure.

## Configuration
- PACKET_BUFFER_STATS_EN defined:
  - Per-port 32-bit drop counters, saturating at 0xFFFFFFFF.
  - A counter increments on every frame_dropped for its port.
  - Counters are cleared by rst_n or by port_flush.
  - stats_drops is registered, one cycle after stats_sel.
- Not defined: no counters; stats_drops is tied to 0 and stats_sel is ignored.

## Test plan
Bench parameters: REGION_BITS=4, NUM_PORTS=4, PORT_BITS=2.
- Port 1: write 5-word frame, wr_drop=0. Expect ram_wr_addr 0x10..0x14, frame_committed once, port_empty[1]=0. Then 5 reads give ram_rd_addr 0x10..0x14; port_empty[1]=1 after the last.
- Port 2: write 20-word frame. Expect 16 RAM writes, frame_dropped, no commit, port_empty[2] stays 1. A following 3-word frame writes 0x20..0x22.
- Port 0: 3-word frame with wr_drop on wr_last. Expect frame_dropped; the next frame starts at address 0x00.
- Wrap-around on port 3: commit 12, read 12, commit 8. Expect addresses 0x3C..0x3F then 0x30..0x33, with no false full.
- Flush of port 1 mid-frame, with port 0 writes in the same cycle. Expect port 0 unaffected; port 1 pointers are 0 and the next frame writes at 0x10.
- With PACKET_BUFFER_STATS_EN: 3 drops on port 2 give stats_drops=3 at stats_sel=2; after port_flush[2], it reads 0.
